// File: rtl/ram_bus_arbiter_if.sv
// Request/grant bus between a master and the shared RAM: same-cycle grants, read data one cycle after the read grant.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
    output rd_gnt, rd_data, wr_gnt
  );
endinterface

// File: rtl/ram_bus_arbiter.sv
// Two-master arbiter for one RAM: m0 has priority, m1 is forced through after STARVE_MAX denied cycles.
// Zero-latency combinational grant path; read data is steered by the owner registered at the read grant.
module ram_bus_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input logic     clk,
  input logic     rst_n,
  naive_bus.slave  m0,
  naive_bus.slave  m1,
  naive_bus.master s
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic       req0;
  logic       req1;
  logic       own_vld;
  logic       own;
  logic       sel0;
  logic       sel1;
  logic       rd_vld;
  logic       rd_own;
  logic [3:0] starve_cnt;

  assign req0 = m0.rd_req | m0.wr_req;
  assign req1 = m1.rd_req | m1.wr_req;

  // Arbitration is gated by rst_n so grants drop the moment reset asserts.
  always_comb begin
    own_vld = 1'b0;
    own     = 1'b0;
    if (rst_n) begin
      if (req0 && req1) begin
        own_vld = 1'b1;
        own     = (starve_cnt == SMAX);
      end else if (req0) begin
        own_vld = 1'b1;
      end else if (req1) begin
        own_vld = 1'b1;
        own     = 1'b1;
      end
    end
  end

  assign sel0 = own_vld & ~own;
  assign sel1 = own_vld & own;

  always_comb begin
    s.rd_req  = (sel0 & m0.rd_req) | (sel1 & m1.rd_req);
    s.wr_req  = (sel0 & m0.wr_req) | (sel1 & m1.wr_req);
    s.rd_addr = '0;
    s.wr_addr = '0;
    s.wr_data = '0;
    s.wr_be   = '0;
    if (sel0) begin
      s.rd_addr = m0.rd_addr;
      s.wr_addr = m0.wr_addr;
      s.wr_data = m0.wr_data;
      s.wr_be   = m0.wr_be;
    end else if (sel1) begin
      s.rd_addr = m1.rd_addr;
      s.wr_addr = m1.wr_addr;
      s.wr_data = m1.wr_data;
      s.wr_be   = m1.wr_be;
    end
  end

  assign m0.rd_gnt  = sel0 & s.rd_gnt;
  assign m0.wr_gnt  = sel0 & s.wr_gnt;
  assign m1.rd_gnt  = sel1 & s.rd_gnt;
  assign m1.wr_gnt  = sel1 & s.wr_gnt;

  assign m0.rd_data = (rd_vld && !rd_own) ? s.rd_data : '0;
  assign m1.rd_data = (rd_vld &&  rd_own) ? s.rd_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld     <= 1'b0;
      rd_own     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      rd_vld <= s.rd_req & s.rd_gnt;
      rd_own <= own;
      // Saturate at the threshold; the forced win then clears it back to 0.
      if (req1 && !sel1) begin
        if (starve_cnt != SMAX) starve_cnt <= starve_cnt + 4'd1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Bench for ram_bus_arbiter: per-cycle vector table with a read-return scoreboard and a reference memory.
module tb_ram_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  naive_bus m0_if ();
  naive_bus m1_if ();
  naive_bus s_if ();

  ram_bus_arbiter #(.STARVE_MAX(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_if.slave),
    .m1    (m1_if.slave),
    .s     (s_if.master)
  );

  // Shared RAM: always grants, registered read of the pre-write contents.
  logic [31:0] ram [0:1023];
  assign s_if.rd_gnt = s_if.rd_req;
  assign s_if.wr_gnt = s_if.wr_req;
  always_ff @(posedge clk) begin
    if (s_if.rd_req) s_if.rd_data <= ram[s_if.rd_addr[11:2]];
    if (s_if.wr_req)
      for (int b = 0; b < 4; b++)
        if (s_if.wr_be[b]) ram[s_if.wr_addr[11:2]][8*b +: 8] <= s_if.wr_data[8*b +: 8];
  end

  typedef struct {
    logic        r0, w0;
    logic [11:0] ra0, wa0;
    logic [31:0] wd0;
    logic [3:0]  be0;
    logic        r1, w1;
    logic [11:0] ra1, wa1;
    logic [31:0] wd1;
    logic [3:0]  be1;
    logic [3:0]  g;   // expected {m0.rd_gnt, m0.wr_gnt, m1.rd_gnt, m1.wr_gnt}
  } vec_t;

  typedef struct {
    logic        vld;
    logic        own;
    logic [31:0] dat;
  } ret_t;

  vec_t        tbl[$];
  ret_t        sb[$];
  logic [31:0] ref_mem [0:1023];
  int          n_chk = 0;
  int          n_err = 0;

  function automatic vec_t mk(logic r0, logic [11:0] ra0, logic w0, logic [11:0] wa0,
                              logic [31:0] wd0, logic [3:0] be0,
                              logic r1, logic [11:0] ra1, logic w1, logic [11:0] wa1,
                              logic [31:0] wd1, logic [3:0] be1, logic [3:0] g);
    vec_t v;
    v.r0 = r0; v.ra0 = ra0; v.w0 = w0; v.wa0 = wa0; v.wd0 = wd0; v.be0 = be0;
    v.r1 = r1; v.ra1 = ra1; v.w1 = w1; v.wa1 = wa1; v.wd1 = wd1; v.be1 = be1;
    v.g = g;
    return v;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, check on the falling edge.
  task automatic step(vec_t v, logic rst, string tag);
    ret_t e;
    ret_t n;
    @(posedge clk);
    #1;
    rst_n = rst;
    m0_if.rd_req = v.r0; m0_if.rd_addr = {20'd0, v.ra0};
    m0_if.wr_req = v.w0; m0_if.wr_addr = {20'd0, v.wa0}; m0_if.wr_data = v.wd0; m0_if.wr_be = v.be0;
    m1_if.rd_req = v.r1; m1_if.rd_addr = {20'd0, v.ra1};
    m1_if.wr_req = v.w1; m1_if.wr_addr = {20'd0, v.wa1}; m1_if.wr_data = v.wd1; m1_if.wr_be = v.be1;
    if (!rst) begin
      sb.delete();
      sb.push_back('{vld: 1'b0, own: 1'b0, dat: 32'd0});
    end
    @(negedge clk);
    chk({tag, " grants"}, {28'd0, m0_if.rd_gnt, m0_if.wr_gnt, m1_if.rd_gnt, m1_if.wr_gnt},
        {28'd0, v.g});
    if (!rst) chk({tag, " s_req_in_reset"}, {30'd0, s_if.rd_req, s_if.wr_req}, 32'd0);
    if (sb.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s scoreboard_empty: got 0 entries expected 1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " m0_rd_data"}, m0_if.rd_data, (e.vld && !e.own) ? e.dat : 32'd0);
      chk({tag, " m1_rd_data"}, m1_if.rd_data, (e.vld &&  e.own) ? e.dat : 32'd0);
    end
    n = '{vld: 1'b0, own: 1'b0, dat: 32'd0};
    if (v.g[3]) n = '{vld: 1'b1, own: 1'b0, dat: ref_mem[v.ra0[11:2]]};
    else if (v.g[1]) n = '{vld: 1'b1, own: 1'b1, dat: ref_mem[v.ra1[11:2]]};
    sb.push_back(n);
    if (v.g[2]) ref_mem[v.wa0[11:2]] = merge(ref_mem[v.wa0[11:2]], v.wd0, v.be0);
    if (v.g[0]) ref_mem[v.wa1[11:2]] = merge(ref_mem[v.wa1[11:2]], v.wd1, v.be1);
  endtask

  initial begin
    vec_t idle;
    vec_t both;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    both = mk(1, 12'h000, 0, 0, 0, 0, 1, 12'h004, 0, 0, 0, 0, 4'b1000);

    tbl.push_back(mk(0, 0, 1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(1, 12'h010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000));
    tbl.push_back(idle);
    tbl.push_back(mk(0, 0, 1, 12'h000, 32'h11111111, 4'hF, 0, 0, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h004, 32'h22222222, 4'hF, 4'b0001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 12'h020, 32'hAABBCCDD, 4'b0010, 4'b0001));
    tbl.push_back(mk(1, 12'h000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12'h004, 0, 0, 0, 0, 4'b0010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12'h020, 0, 0, 0, 0, 4'b0010));
    tbl.push_back(idle);
    tbl.push_back(mk(1, 12'h010, 1, 12'h000, 32'h55555555, 4'hF, 0, 0, 0, 0, 0, 0, 4'b1100));
    tbl.push_back(idle);
    for (int i = 0; i < 8; i++) begin
      vec_t c;
      c = both;
      c.g = (i % 4 == 3) ? 4'b0010 : 4'b1000;
      tbl.push_back(c);
    end
    tbl.push_back(idle);
    tbl.push_back(mk(0, 0, 1, 12'h030, 32'h12345678, 4'b1001, 1, 12'h004, 0, 0, 0, 0, 4'b0100));
    tbl.push_back(mk(1, 12'h030, 0, 0, 0, 0, 1, 12'h004, 0, 0, 0, 0, 4'b1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 12'h004, 0, 0, 0, 0, 4'b0010));
    tbl.push_back(both);
    tbl.push_back(idle);

    // Reset held with requests asserted: nothing may leak out.
    sb.push_back('{vld: 1'b0, own: 1'b0, dat: 32'd0});
    begin
      vec_t rv;
      rv = both;
      rv.w1 = 1'b1; rv.wa1 = 12'h040; rv.wd1 = 32'hFFFFFFFF; rv.be1 = 4'hF;
      rv.g = 4'b0000;
      step(rv, 1'b0, "reset_hold");
    end
    step(idle, 1'b1, "reset_release");

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Build starvation to the threshold, then reset right after an m0 read grant.
    step(both, 1'b1, "pre_rst_a");
    step(both, 1'b1, "pre_rst_b");
    step(both, 1'b1, "pre_rst_c");
    begin
      vec_t rv;
      rv = both;
      rv.g = 4'b0000;
      step(rv, 1'b0, "mid_read_reset");
    end
    step(both, 1'b1, "post_rst_first");
    step(both, 1'b1, "post_rst_second");
    step(idle, 1'b1, "post_rst_idle");
    step(idle, 1'b1, "final_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_bus_arbiter.md
RAM_BUS_ARBITER -- requirements
Module: ram_bus_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, default 3, legal range 1..15; the number of consecutive denied cycles after which master 1 is forced to win.
REQ-002 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 Port: m0, naive_bus.slave, interface, master 0 (data port, high priority).
REQ-005 Port: m1, naive_bus.slave, interface, master 1 (instruction-fetch port, low priority).
REQ-006 Port: s, naive_bus.master, interface, shared 4 kB RAM slave; it grants in the same cycle as the request and returns read data one cycle after the read grant.

Function
REQ-007 Each cycle the arbiter shall select exactly one owner among the requesting masters; a master requests when its rd_req or wr_req is high.
REQ-008 Owner selection shall follow these rules:
- Only m0 requests: owner = m0.
- Only m1 requests: owner = m1.
- Both request: owner = m0, unless starve_cnt == STARVE_MAX, in which case owner = m1.
- Neither requests: no owner.
REQ-009 The owner's rd_req, rd_addr, wr_req, wr_addr, wr_data and wr_be shall pass combinationally to s; with no owner, s.rd_req = s.wr_req = 0 and all other s outputs = 0.
REQ-010 The owner's rd_gnt and wr_gnt shall equal s.rd_gnt and s.wr_gnt; the non-owner's grants shall be 0.
REQ-011 The owner may issue a read and a write in the same cycle; both shall be forwarded and both granted.
REQ-012 A non-owner shall hold its request; the arbiter keeps no request queue.
REQ-013 Read-return state shall be registered each cycle:
- rd_vld <= s.rd_req & s.rd_gnt.
- rd_own <= owner index (0 or 1).
REQ-014 In the cycle after a read grant, m[rd_own].rd_data shall equal s.rd_data; the other master's rd_data shall be 0. When rd_vld = 0, both rd_data outputs shall be 0.
REQ-015 Back-to-back reads from different masters shall route correctly: each cycle's read data goes to the master granted in the previous cycle.
REQ-016 starve_cnt shall be 4 bits wide and update as follows:
- m1 requesting and not owner: increment, saturating at STARVE_MAX.
- m1 owner, or m1 not requesting: 0.
REQ-017 A forced m1 grant shall last exactly one cycle: starve_cnt returns to 0, so m0 regains priority on the next contended cycle.
REQ-018 Write completion is the grant cycle; the arbiter adds no write latency.

Reset
REQ-019 While rst_n = 0, the arbiter shall hold:
- rd_vld = 0, rd_own = 0, starve_cnt = 0.
- All grants to m0/m1 = 0.
- s.rd_req = s.wr_req = 0.
- All rd_data outputs = 0.
REQ-020 Asserting rst_n mid-transaction shall immediately drop all grants and discard the pending read return; the first cycle after deassertion behaves as a fresh arbitration with starve_cnt = 0.

Verification
REQ-021 Single master: m0 writes 0xDEADBEEF to 0x010 with wr_be = 4'b1111, then reads 0x010 -> m0.wr_gnt = 1 in the write cycle; m0.rd_data = 0xDEADBEEF one cycle after rd_gnt; m1 grants stay 0.
REQ-022 Contention with STARVE_MAX = 3: m0 and m1 read continuously -> m0 owns 3 cycles, m1 owns the 4th, and the pattern repeats.
REQ-023 Interleaved return: m0 reads 0x000 (holding 0x11111111) in cycle N, m1 reads 0x004 (holding 0x22222222) in cycle N+1 -> m0.rd_data = 0x11111111 in N+1, m1.rd_data = 0x22222222 in N+2, and the other master's rd_data = 0 in each of those cycles.
REQ-024 Byte enables through m1: m1 writes 0xAABBCCDD with wr_be = 4'b0010 to a word holding 0 -> a subsequent read returns 0x0000CC00.
REQ-025 Reset mid-read: rst_n is pulsed low in the cycle after an m0 read grant -> m0.rd_data = 0 during reset; after release starve_cnt = 0 and m0 wins the first contended cycle.
REQ-026 Simultaneous read and write by the owner to different addresses -> both granted in the same cycle; the read returns the old data one cycle later.
